// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: size encodings, channel ids,
// grant-lock state and small index helpers.
package sram_bus_arbiter_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int CH_INST = 0;
    localparam int CH_DATA = 1;

    typedef enum logic {
        GRANT_FREE,
        GRANT_LOCKED
    } lock_state_e;

    // A single channel still needs a one-bit tag.
    function automatic int ch_id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int next_ch(input int cur, input int num_ch);
        return (cur + 1 >= num_ch) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_resp_tag_fifo.sv
// Tag FIFO remembering which channel issued each outstanding request, so
// in-order responses can be routed back to their requester.
module resp_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [TAG_W-1:0] din,
    output logic [TAG_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0] tags [DEPTH];
    logic [IDX_W:0]   wr_ptr;
    logic [IDX_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign dout  = tags[rd_ptr[IDX_W-1:0]];

    // The top bit flips on every wrap, which separates full from empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                if (wr_ptr[IDX_W-1:0] == IDX_W'(DEPTH - 1))
                    wr_ptr <= {~wr_ptr[IDX_W], {IDX_W{1'b0}}};
                else
                    wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                if (rd_ptr[IDX_W-1:0] == IDX_W'(DEPTH - 1))
                    rd_ptr <= {~rd_ptr[IDX_W], {IDX_W{1'b0}}};
                else
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            tags[wr_ptr[IDX_W-1:0]] <= din;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one SRAM-like request/response bus between
// NUM_CH pipeline memory ports, with in-order response routing.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_wr,
    input  logic [2*NUM_CH-1:0]          ch_size,
    input  logic [NUM_CH*(DATA_W/8)-1:0] ch_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]            ch_addr_ok,
    output logic [NUM_CH-1:0]            ch_data_ok,
    output logic [DATA_W-1:0]            ch_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [DATA_W/8-1:0]          mem_wstrb,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         proto_err
);

    localparam int CH_ID_W = ch_id_width(NUM_CH);
    localparam int STRB_W  = DATA_W / 8;

    lock_state_e        lock_state;
    logic [CH_ID_W-1:0] lock_ch;
    logic [CH_ID_W-1:0] rr_ptr;
    logic [CH_ID_W-1:0] rr_pick;
    logic [CH_ID_W-1:0] grant;
    logic [CH_ID_W-1:0] head_tag;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               resp;

    // First requesting channel at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        logic [CH_ID_W:0] cand;
        logic             found;
        rr_pick = rr_ptr;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, rr_ptr} + (CH_ID_W+1)'(k);
            if (cand >= (CH_ID_W+1)'(NUM_CH))
                cand = cand - (CH_ID_W+1)'(NUM_CH);
            if (!found && ch_req[cand[CH_ID_W-1:0]]) begin
                rr_pick = cand[CH_ID_W-1:0];
                found   = 1'b1;
            end
        end
    end

    assign grant   = (lock_state == GRANT_LOCKED) ? lock_ch : rr_pick;
    assign mem_req = (|ch_req) & ~fifo_full;
    assign accept  = mem_req & mem_addr_ok;
    assign resp    = mem_data_ok & ~fifo_empty;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == CH_ID_W'(i)) begin
                mem_wr    = ch_wr[i];
                mem_size  = ch_size[2*i +: 2];
                mem_wstrb = ch_wstrb[STRB_W*i +: STRB_W];
                mem_addr  = ch_addr[ADDR_W*i +: ADDR_W];
                mem_wdata = ch_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr_ok[i] = accept & (grant == CH_ID_W'(i));
            ch_data_ok[i] = resp & (head_tag == CH_ID_W'(i));
        end
    end

    assign ch_rdata = mem_rdata;

    // A stalled request freezes its grant so the downstream sees a stable
    // request; a full FIFO leaves the lock untouched because nothing is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state <= GRANT_FREE;
            lock_ch    <= '0;
            rr_ptr     <= '0;
        end else begin
            case (lock_state)
                GRANT_FREE: begin
                    if (accept) begin
                        rr_ptr <= CH_ID_W'(next_ch(int'(grant), NUM_CH));
                    end else if (mem_req) begin
                        lock_state <= GRANT_LOCKED;
                        lock_ch    <= grant;
                    end
                end
                GRANT_LOCKED: begin
                    if (accept) begin
                        lock_state <= GRANT_FREE;
                        rr_ptr     <= CH_ID_W'(next_ch(int'(grant), NUM_CH));
                    end
                end
                default: lock_state <= GRANT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            proto_err <= 1'b0;
        else if (mem_data_ok && fifo_empty)
            proto_err <= 1'b1;
    end

    resp_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .TAG_W (CH_ID_W)
    ) u_tag_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (resp),
        .din    (grant),
        .dout   (head_tag),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule
